// File: rtl/leading_ones_pkg.sv
// -----------------------------------------------------------------------------
// leading_ones_pkg
// Shared definitions for the leading-ones encoder/decoder pair.
//   lod_state_t  : control FSM states (IDLE, FILL)
//   DEFAULT_BITS : default thermometer width
//   code_width() : width of a count code able to hold 0..bits inclusive
// -----------------------------------------------------------------------------
package leading_ones_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } lod_state_t;

    localparam int DEFAULT_BITS = 16;

    // A code must represent the value "bits" itself, hence the extra bit.
    function automatic int code_width(input int bits);
        return $clog2(bits) + 1;
    endfunction

endpackage

// File: rtl/leading_ones_decoder_if.sv
// -----------------------------------------------------------------------------
// leading_ones_decoder_if
// Command channel into the leading-ones decoder.
//   in_valid : command valid              (master -> slave)
//   in_code  : requested count, CW bits   (master -> slave)
//   in_ready : slave can accept a command (slave -> master)
// -----------------------------------------------------------------------------
interface leading_ones_decoder_if #(
    parameter int BITS = 16
) ();
    import leading_ones_pkg::*;

    localparam int CW = code_width(BITS);

    logic          in_valid;
    logic [CW-1:0] in_code;
    logic          in_ready;

    modport master (
        output in_valid,
        output in_code,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_code,
        output in_ready
    );

endinterface

// File: rtl/step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
// Free-running divider that paces the thermometer fill.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : force the count back to zero (wins over enable)
//   enable     : advance the count by one each cycle
//   tick       : high while enabled and sitting on the terminal count
//                (STEP_CYCLES-1); the count wraps to zero on that edge
// -----------------------------------------------------------------------------
module step_timer #(
    parameter int STEP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TW-1:0] TERM = TW'(STEP_CYCLES - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;
    logic          at_term_s;

    assign at_term_s = (cnt_q == TERM);
    assign tick      = enable & at_term_s & ~clear;

    // Next-count computation: clear, wrap on terminal count, or increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {TW{1'b0}};
        end else if (enable) begin
            if (at_term_s) begin
                cnt_d = {TW{1'b0}};
            end else begin
                cnt_d = cnt_q + TW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {TW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/leading_ones_decoder.sv
// -----------------------------------------------------------------------------
// leading_ones_decoder
// Turns a count code (0..BITS) into a BITS-wide thermometer pattern that
// fills from bit 0 upward, one bit every STEP_CYCLES clocks.
//   clk, rst_n : clock, synchronous active-low reset
//   cmd        : command channel (in_valid / in_code / in_ready), slave side
//   abort      : stop an in-progress fill, leaving the partial pattern
//   LED        : thermometer pattern, held in IDLE until the next legal accept
//   busy       : fill in progress
//   done       : one-cycle pulse when a fill (or a zero code) completes
//   err        : one-cycle pulse when an out-of-range code is accepted
// All outputs are registered; in_ready depends only on the FSM state.
// -----------------------------------------------------------------------------
module leading_ones_decoder
    import leading_ones_pkg::*;
#(
    parameter int BITS        = DEFAULT_BITS,
    parameter int STEP_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    leading_ones_decoder_if.slave cmd,
    input  logic                  abort,
    output logic [BITS-1:0]       LED,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CW = code_width(BITS);
    // BITS expressed at code width; CW always has room for BITS itself,
    // so the range check below never truncates.
    localparam logic [CW-1:0] BITS_CODE = CW'(BITS);

    lod_state_t      state_q;
    lod_state_t      state_d;
    logic [BITS-1:0] led_q;
    logic [BITS-1:0] led_d;
    logic [CW-1:0]   fill_cnt_q;
    logic [CW-1:0]   fill_cnt_d;
    logic [CW-1:0]   target_q;
    logic [CW-1:0]   target_d;
    logic            in_ready_q;
    logic            in_ready_d;
    logic            busy_q;
    logic            busy_d;
    logic            done_q;
    logic            done_d;
    logic            err_q;
    logic            err_d;

    logic            accept_s;
    logic            tick_s;
    logic            timer_clear_s;
    logic            timer_enable_s;
    logic [CW-1:0]   fill_cnt_inc_s;

    assign accept_s       = cmd.in_valid & in_ready_q;
    assign fill_cnt_inc_s = fill_cnt_q + CW'(1);

    // The timer only runs while filling; abort resets it on the same edge
    // that drops the FSM back to IDLE.
    assign timer_enable_s = (state_q == FILL);
    assign timer_clear_s  = (state_q != FILL) | abort;

    step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear_s),
        .enable (timer_enable_s),
        .tick   (tick_s)
    );

    // FSM next-state, LED shift and pulse generation.
    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        fill_cnt_d = fill_cnt_q;
        target_d   = target_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (cmd.in_code > BITS_CODE) begin
                        err_d = 1'b1;
                    end else if (cmd.in_code == {CW{1'b0}}) begin
                        led_d  = {BITS{1'b0}};
                        done_d = 1'b1;
                    end else begin
                        led_d      = {BITS{1'b0}};
                        target_d   = cmd.in_code;
                        fill_cnt_d = {CW{1'b0}};
                        state_d    = FILL;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            FILL: begin
                // abort takes priority even over the final bit.
                if (abort) begin
                    fill_cnt_d = {CW{1'b0}};
                    state_d    = IDLE;
                end else if (tick_s) begin
                    led_d      = {led_q[BITS-2:0], 1'b1};
                    fill_cnt_d = fill_cnt_inc_s;
                    if (fill_cnt_inc_s == target_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end

            default: begin
                state_d    = IDLE;
                fill_cnt_d = {CW{1'b0}};
            end
        endcase

        // Status flags follow the next state so they change together with it.
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d == FILL);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            led_q      <= {BITS{1'b0}};
            fill_cnt_q <= {CW{1'b0}};
            target_q   <= {CW{1'b0}};
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            led_q      <= led_d;
            fill_cnt_q <= fill_cnt_d;
            target_q   <= target_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cmd.in_ready = in_ready_q;
    assign LED          = led_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_leading_ones_decoder.sv
module tb_leading_ones_decoder;
    import leading_ones_pkg::*;

    localparam int BITS = 16;
    localparam int STEP = 4;
    localparam int CW   = code_width(BITS);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            abort_a = 1'b0;
    logic            abort_b = 1'b0;
    logic [BITS-1:0] led_a, led_b;
    logic            busy_a, busy_b, done_a, done_b, err_a, err_b;

    int compared = 0;
    int failed   = 0;

    always #5 clk = ~clk;

    leading_ones_decoder_if #(.BITS(BITS)) cmd_a ();
    leading_ones_decoder_if #(.BITS(BITS)) cmd_b ();

    leading_ones_decoder #(.BITS(BITS), .STEP_CYCLES(STEP)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd(cmd_a), .abort(abort_a),
        .LED(led_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    leading_ones_decoder #(.BITS(BITS), .STEP_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd(cmd_b), .abort(abort_b),
        .LED(led_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    // Independent reference: thermometer of n ones, and leading-ones encoder.
    function automatic logic [15:0] therm(input int n);
        logic [31:0] t;
        if (n >= 32) t = 32'hFFFF_FFFF;
        else         t = (32'd1 << n) - 32'd1;
        return t[15:0];
    endfunction

    function automatic int encode(input logic [15:0] v);
        int n = 0;
        for (int i = 0; i < 16; i++) begin
            if (v[i] && n == i) n++;
        end
        return n;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, then present one command for one edge.
    task automatic send_a(input int code);
        int guard = 0;
        while (cmd_a.in_ready !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        compared++;
        if (cmd_a.in_ready !== 1'b1) begin
            failed++;
            $display("FAIL send_ready code=%0d got=%b exp=1", code, cmd_a.in_ready);
        end
        cmd_a.in_valid = 1'b1;
        cmd_a.in_code  = CW'(code);
        tick();
        cmd_a.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        compared++;
        if (led_a !== 16'h0000 || cmd_a.in_ready !== 1'b1 || busy_a !== 1'b0 ||
            done_a !== 1'b0 || err_a !== 1'b0) begin
            failed++;
            $display("FAIL reset_state got led=%h rdy=%b busy=%b done=%b err=%b exp 0000/1/0/0/0",
                     led_a, cmd_a.in_ready, busy_a, done_a, err_a);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill(input int code);
        int total = code * STEP;
        send_a(code);
        compared++;
        if (led_a !== 16'h0000 || cmd_a.in_ready !== 1'b0 || busy_a !== 1'b1) begin
            failed++;
            $display("FAIL fill%0d_accept got led=%h rdy=%b busy=%b exp 0000/0/1",
                     code, led_a, cmd_a.in_ready, busy_a);
        end
        for (int c = 1; c <= total; c++) begin
            tick();
            compared++;
            if (led_a !== therm(c / STEP) || done_a !== (c == total) ||
                cmd_a.in_ready !== (c == total) || busy_a !== (c != total)) begin
                failed++;
                $display("FAIL fill%0d_cycle%0d got led=%h done=%b rdy=%b busy=%b exp led=%h done=%b rdy=%b",
                         code, c, led_a, done_a, cmd_a.in_ready, busy_a,
                         therm(c / STEP), (c == total), (c == total));
            end
        end
        tick();
        compared++;
        if (done_a !== 1'b0 || encode(led_a) != code) begin
            failed++;
            $display("FAIL fill%0d_final got done=%b enc=%0d exp done=0 enc=%0d",
                     code, done_a, encode(led_a), code);
        end
    endtask

    task automatic test_zero_and_illegal;
        test_fill(8);
        send_a(17);
        compared++;
        if (err_a !== 1'b1 || done_a !== 1'b0 || led_a !== 16'h00FF || busy_a !== 1'b0) begin
            failed++;
            $display("FAIL illegal17 got err=%b done=%b led=%h busy=%b exp 1/0/00ff/0",
                     err_a, done_a, led_a, busy_a);
        end
        tick();
        compared++;
        if (err_a !== 1'b0) begin
            failed++;
            $display("FAIL illegal17_pulse got err=%b exp 0", err_a);
        end
        send_a(31);
        compared++;
        if (err_a !== 1'b1 || led_a !== 16'h00FF) begin
            failed++;
            $display("FAIL illegal31 got err=%b led=%h exp 1/00ff", err_a, led_a);
        end
        send_a(0);
        compared++;
        if (led_a !== 16'h0000 || done_a !== 1'b1 || err_a !== 1'b0) begin
            failed++;
            $display("FAIL zero_code got led=%h done=%b err=%b exp 0000/1/0", led_a, done_a, err_a);
        end
        tick();
        compared++;
        if (done_a !== 1'b0) begin
            failed++;
            $display("FAIL zero_pulse got done=%b exp 0", done_a);
        end
    endtask

    task automatic test_abort;
        send_a(8);
        for (int c = 1; c < 14; c++) tick();
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        compared++;
        if (led_a !== 16'h0007 || done_a !== 1'b0 || cmd_a.in_ready !== 1'b1 || busy_a !== 1'b0) begin
            failed++;
            $display("FAIL abort8 got led=%h done=%b rdy=%b busy=%b exp 0007/0/1/0",
                     led_a, done_a, cmd_a.in_ready, busy_a);
        end
        for (int c = 0; c < 3; c++) tick();
        compared++;
        if (led_a !== 16'h0007 || done_a !== 1'b0) begin
            failed++;
            $display("FAIL abort8_hold got led=%h done=%b exp 0007/0", led_a, done_a);
        end
        send_a(3);
        for (int c = 1; c < 12; c++) tick();
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        compared++;
        if (led_a !== 16'h0003 || done_a !== 1'b0 || cmd_a.in_ready !== 1'b1) begin
            failed++;
            $display("FAIL abort3_final got led=%h done=%b rdy=%b exp 0003/0/1",
                     led_a, done_a, cmd_a.in_ready);
        end
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        compared++;
        if (led_a !== 16'h0003 || busy_a !== 1'b0 || cmd_a.in_ready !== 1'b1 || done_a !== 1'b0) begin
            failed++;
            $display("FAIL abort_idle got led=%h busy=%b rdy=%b done=%b exp 0003/0/1/0",
                     led_a, busy_a, cmd_a.in_ready, done_a);
        end
    endtask

    task automatic test_reset_midfill;
        send_a(10);
        for (int c = 1; c < 9; c++) begin
            tick();
            compared++;
            if (done_a !== 1'b0) begin
                failed++;
                $display("FAIL midreset_pre c=%0d got done=%b exp 0", c, done_a);
            end
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        compared++;
        if (led_a !== 16'h0000 || busy_a !== 1'b0 || done_a !== 1'b0 || cmd_a.in_ready !== 1'b1) begin
            failed++;
            $display("FAIL midreset got led=%h busy=%b done=%b rdy=%b exp 0000/0/0/1",
                     led_a, busy_a, done_a, cmd_a.in_ready);
        end
        for (int c = 0; c < 45; c++) begin
            tick();
            compared++;
            if (done_a !== 1'b0 || busy_a !== 1'b0) begin
                failed++;
                $display("FAIL midreset_quiet c=%0d got done=%b busy=%b exp 0/0", c, done_a, busy_a);
            end
        end
        test_fill(2);
    endtask

    task automatic test_back_to_back;
        int codes[20] = '{5, 0, 16, 1, 0, 0, 7, 3, 16, 2, 9, 15, 8, 4, 12, 6, 10, 11, 13, 14};
        int idx = 0;
        int elapsed = 0;
        int cyc = 0;
        int exp_lat;
        bit err_seen = 1'b0;
        cmd_b.in_code  = CW'(codes[0]);
        cmd_b.in_valid = 1'b1;
        while (idx < 20 && cyc < 2000) begin
            tick();
            cyc++;
            elapsed++;
            if (err_b === 1'b1) err_seen = 1'b1;
            if (done_b === 1'b1) begin
                exp_lat = (codes[idx] == 0) ? 1 : codes[idx] + 1;
                compared++;
                if (encode(led_b) != codes[idx] || elapsed != exp_lat) begin
                    failed++;
                    $display("FAIL b2b_cmd%0d got enc=%0d lat=%0d exp enc=%0d lat=%0d",
                             idx, encode(led_b), elapsed, codes[idx], exp_lat);
                end
                elapsed = 0;
                idx++;
                if (idx < 20) cmd_b.in_code = CW'(codes[idx]);
                else          cmd_b.in_valid = 1'b0;
            end
        end
        cmd_b.in_valid = 1'b0;
        compared++;
        if (idx != 20) begin
            failed++;
            $display("FAIL b2b_timeout got dones=%0d exp 20", idx);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done_b === 1'b1) idx++;
        end
        compared++;
        if (idx != 20 || err_seen) begin
            failed++;
            $display("FAIL b2b_extra got dones=%0d err_seen=%b exp 20/0", idx, err_seen);
        end
    endtask

    initial begin
        cmd_a.in_valid = 1'b0;
        cmd_a.in_code  = {CW{1'b0}};
        cmd_b.in_valid = 1'b0;
        cmd_b.in_code  = {CW{1'b0}};
        test_reset();
        test_fill(5);
        test_fill(16);
        test_fill(1);
        test_zero_and_illegal();
        test_abort();
        test_reset_midfill();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
